// File: rtl/sponge_absorb_ctrl.sv
// sponge_absorb_ctrl: absorbs RATE-bit blocks into a sponge state, drives an external
// permutation core over start/done, and squeezes OUT_BLOCKS digest blocks.
// Optional permutation watchdog enabled by defining SPONGE_PERM_TIMEOUT_EN.
module sponge_absorb_ctrl #(
    parameter int RATE         = 256,
    parameter int STATE_WIDTH  = 512,
    parameter int OUT_BLOCKS   = 1,
    parameter int PERM_TIMEOUT = 64
) (
    input  logic                   i_clk,
    input  logic                   i_clear_n,
    input  logic [RATE-1:0]        i_in_block,
    input  logic                   i_in_ready,
    input  logic                   i_in_last,
    output logic                   o_perm_start,
    output logic [STATE_WIDTH-1:0] o_perm_state_in,
    input  logic [STATE_WIDTH-1:0] i_perm_state_out,
    input  logic                   i_perm_done,
    output logic [RATE-1:0]        o_digest,
    output logic                   o_digest_valid,
    input  logic                   i_digest_ready,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_overrun,
    output logic                   o_perm_timeout
);
    localparam int CW = $clog2(OUT_BLOCKS + 1);

    typedef enum logic [2:0] {ABSORB, PERM, SQ_OUT, SQ_PERM, DONE} state_t;

    if (RATE >= STATE_WIDTH || OUT_BLOCKS < 1 || PERM_TIMEOUT < 2) begin : g_bad_params
        $error("sponge_absorb_ctrl: illegal parameter combination");
    end

    state_t                 r_fsm, w_fsm_nxt;
    logic [STATE_WIDTH-1:0] r_state, w_state_nxt;
    logic                   r_in_ready_q;
    logic                   r_last;
    logic                   r_busy;
    logic                   r_overrun;
    logic                   r_perm_start, w_perm_start_nxt;
    logic                   r_pend;
    logic [RATE-1:0]        r_pend_block;
    logic                   r_pend_last;
    logic [CW-1:0]          r_out_cnt;
    logic [CW-1:0]          w_cnt_inc;
    logic                   w_edge, w_take, w_take_last, w_after_last, w_drop, w_to_pend;
    logic [RATE-1:0]        w_take_block;
    logic                   w_in_perm, w_pdone, w_hs, w_final, w_tmo;

    assign w_edge       = i_in_ready & ~r_in_ready_q;
    assign w_take       = (r_fsm == ABSORB) & (r_pend | w_edge);
    assign w_take_block = r_pend ? r_pend_block : i_in_block;
    assign w_take_last  = r_pend ? r_pend_last : i_in_last;
    assign w_after_last = r_last | (r_pend & r_pend_last) | (r_fsm == DONE);
    assign w_drop       = w_edge & (w_after_last | (r_pend & (r_fsm != ABSORB)));
    assign w_to_pend    = w_edge & ~w_drop & ((r_fsm != ABSORB) | r_pend);
    assign w_in_perm    = (r_fsm == PERM) | (r_fsm == SQ_PERM);
    assign w_pdone      = i_perm_done & ~r_perm_start & w_in_perm;
    assign w_hs         = (r_fsm == SQ_OUT) & i_digest_ready;
    assign w_cnt_inc    = r_out_cnt + 1'b1;
    assign w_final      = (w_cnt_inc == CW'(OUT_BLOCKS));

    assign o_perm_start    = r_perm_start;
    assign o_perm_state_in = r_state;
    assign o_digest        = r_state[RATE-1:0];
    assign o_digest_valid  = (r_fsm == SQ_OUT);
    assign o_busy          = r_busy;
    assign o_done          = (r_fsm == DONE) & ~o_perm_timeout;
    assign o_overrun       = r_overrun;

`ifdef SPONGE_PERM_TIMEOUT_EN
    localparam int TW = $clog2(PERM_TIMEOUT + 1);

    logic [TW-1:0] r_tcnt;
    logic          r_tmo;

    assign w_tmo          = w_in_perm & ~r_perm_start & ~w_pdone & (r_tcnt == TW'(PERM_TIMEOUT - 1));
    assign o_perm_timeout = r_tmo;

    // Watchdog: count cycles since the last perm_start while waiting on the core
    always_ff @(posedge i_clk or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_tcnt <= '0;
            r_tmo  <= 1'b0;
        end else begin
            if (r_perm_start)
                r_tcnt <= TW'(1);
            else if (w_in_perm)
                r_tcnt <= r_tcnt + 1'b1;
            if (w_tmo)
                r_tmo <= 1'b1;
        end
    end
`else
    assign w_tmo          = 1'b0;
    assign o_perm_timeout = 1'b0;
`endif

    // Next-state, state update and permutation launch decisions
    always_comb begin
        w_fsm_nxt        = r_fsm;
        w_state_nxt      = r_state;
        w_perm_start_nxt = 1'b0;
        case (r_fsm)
            ABSORB: begin
                if (w_take) begin
                    w_state_nxt[RATE-1:0] = r_state[RATE-1:0] ^ w_take_block;
                    w_perm_start_nxt      = 1'b1;
                    w_fsm_nxt             = PERM;
                end
            end
            PERM: begin
                if (w_pdone) begin
                    w_state_nxt = i_perm_state_out;
                    if (r_last)
                        w_fsm_nxt = SQ_OUT;
                    else
                        w_fsm_nxt = ABSORB;
                end else if (w_tmo) begin
                    w_fsm_nxt = DONE;
                end
            end
            SQ_OUT: begin
                if (w_hs) begin
                    w_perm_start_nxt = ~w_final;
                    if (w_final)
                        w_fsm_nxt = DONE;
                    else
                        w_fsm_nxt = SQ_PERM;
                end
            end
            SQ_PERM: begin
                if (w_pdone) begin
                    w_state_nxt = i_perm_state_out;
                    w_fsm_nxt   = SQ_OUT;
                end else if (w_tmo) begin
                    w_fsm_nxt = DONE;
                end
            end
            default: w_fsm_nxt = DONE;
        endcase
    end

    // Main control registers and sponge state
    always_ff @(posedge i_clk or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_fsm        <= ABSORB;
            r_state      <= '0;
            r_in_ready_q <= 1'b0;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
            r_perm_start <= 1'b0;
            r_out_cnt    <= '0;
        end else begin
            r_fsm        <= w_fsm_nxt;
            r_state      <= w_state_nxt;
            r_in_ready_q <= i_in_ready;
            r_perm_start <= w_perm_start_nxt;
            if (w_take)
                r_last <= w_take_last;
            if (w_fsm_nxt == DONE)
                r_busy <= 1'b0;
            else if (w_take)
                r_busy <= 1'b1;
            if (w_drop)
                r_overrun <= 1'b1;
            if (w_hs)
                r_out_cnt <= w_cnt_inc;
        end
    end

    // One-deep pending slot for blocks arriving while not absorbing
    always_ff @(posedge i_clk or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_pend       <= 1'b0;
            r_pend_block <= '0;
            r_pend_last  <= 1'b0;
        end else if (w_to_pend) begin
            r_pend       <= 1'b1;
            r_pend_block <= i_in_block;
            r_pend_last  <= i_in_last;
        end else if (w_take && r_pend) begin
            r_pend <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sponge_absorb_ctrl.sv
// tb_sponge_absorb_ctrl: directed bench for sponge_absorb_ctrl (OUT_BLOCKS=1 and 3 instances)
module tb_sponge_absorb_ctrl;
    localparam int RATE = 256;
    localparam int SW   = 512;

    logic            clk = 1'b0;
    logic            clear_n, in_ready, in_last, digest_ready, hold_done;
    logic [RATE-1:0] in_block;
    int              errors = 0;
    int              checks = 0;

    logic            ps1, pd1, dv1, busy1, done1, ovr1, tmo1;
    logic [SW-1:0]   psi1, pso1, sv1;
    logic [RATE-1:0] dg1;
    logic            ps3, pd3, dv3, busy3, done3, ovr3, tmo3;
    logic [SW-1:0]   psi3, pso3, sv3;
    logic [RATE-1:0] dg3;
    int              cnt1 = 0, cnt3 = 0, nps1 = 0, nps3 = 0, nhs3 = 0;

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] perm(input logic [SW-1:0] s);
        return {s[SW-2:0], s[SW-1]} ^ {{(SW-1){1'b0}}, 1'b1};
    endfunction

    sponge_absorb_ctrl #(.RATE(RATE), .STATE_WIDTH(SW), .OUT_BLOCKS(1), .PERM_TIMEOUT(64)) dut1 (
        .i_clk(clk), .i_clear_n(clear_n), .i_in_block(in_block), .i_in_ready(in_ready),
        .i_in_last(in_last), .o_perm_start(ps1), .o_perm_state_in(psi1), .i_perm_state_out(pso1),
        .i_perm_done(pd1), .o_digest(dg1), .o_digest_valid(dv1), .i_digest_ready(digest_ready),
        .o_busy(busy1), .o_done(done1), .o_overrun(ovr1), .o_perm_timeout(tmo1));

    sponge_absorb_ctrl #(.RATE(RATE), .STATE_WIDTH(SW), .OUT_BLOCKS(3), .PERM_TIMEOUT(64)) dut3 (
        .i_clk(clk), .i_clear_n(clear_n), .i_in_block(in_block), .i_in_ready(in_ready),
        .i_in_last(in_last), .o_perm_start(ps3), .o_perm_state_in(psi3), .i_perm_state_out(pso3),
        .i_perm_done(pd3), .o_digest(dg3), .o_digest_valid(dv3), .i_digest_ready(digest_ready),
        .o_busy(busy3), .o_done(done3), .o_overrun(ovr3), .o_perm_timeout(tmo3));

    // Permutation core models: done pulse 10 cycles after start, independent of DUT reset
    always @(posedge clk) begin
        if (ps1) begin cnt1 <= 10; sv1 <= psi1; end
        else if (cnt1 != 0) cnt1 <= cnt1 - 1;
        if (ps3) begin cnt3 <= 10; sv3 <= psi3; end
        else if (cnt3 != 0) cnt3 <= cnt3 - 1;
        if (ps1) nps1 <= nps1 + 1;
        if (ps3) nps3 <= nps3 + 1;
        if (dv3 && digest_ready) nhs3 <= nhs3 + 1;
    end
    assign pd1  = (cnt1 == 1) & ~hold_done;
    assign pd3  = (cnt3 == 1) & ~hold_done;
    assign pso1 = perm(sv1);
    assign pso3 = perm(sv3);

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        clear_n = 1'b0; in_ready = 1'b0; in_last = 1'b0; digest_ready = 1'b1;
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [RATE-1:0] b, input logic last);
        @(negedge clk);
        in_block = b; in_last = last; in_ready = 1'b1;
        @(negedge clk);
        in_ready = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_dv(input string tag, input logic three);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (three ? dv3 : dv1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk1(tag, ok, 1'b1);
    endtask

    initial begin
        logic [SW-1:0]   g;
        logic [RATE-1:0] a, b, c;
        int              base, hbase;
        hold_done = 1'b0;
        in_block  = '0;
        do_reset();
        chk1("rst_busy", busy1, 1'b0);
        chk1("rst_done", done1, 1'b0);
        chk1("rst_dv", dv1, 1'b0);
        chk1("rst_ps", ps1, 1'b0);
        chk1("rst_ovr", ovr1, 1'b0);
        chk1("rst_tmo", tmo1, 1'b0);
        chkw("rst_psi", psi1, '0);

        // 1: single last block
        b = {32{8'hAA}};
        base = nps1;
        send(b, 1'b1);
        chk1("s1_ps", ps1, 1'b1);
        chkw("s1_psi", psi1, {256'b0, b});
        chk1("s1_busy", busy1, 1'b1);
        @(negedge clk);
        chk1("s1_ps_pulse", ps1, 1'b0);
        wait_dv("s1_dv_seen", 1'b0);
        g = perm({256'b0, b});
        chkw("s1_digest", {256'b0, dg1}, {256'b0, g[RATE-1:0]});
        @(negedge clk);
        chk1("s1_done", done1, 1'b1);
        chk1("s1_busy_off", busy1, 1'b0);
        chk1("s1_dv_off", dv1, 1'b0);
        chki("s1_nps", nps1 - base, 1);
        send(b, 1'b0);
        chk1("s1_ovr_after_done", ovr1, 1'b1);
        chk1("s1_done_sticky", done1, 1'b1);

        // 2: three chained blocks
        do_reset();
        base = nps1;
        g = '0;
        for (int k = 1; k <= 3; k++) begin
            a = {32{8'(k)}};
            send(a, k == 3);
            g[RATE-1:0] = g[RATE-1:0] ^ a;
            g = perm(g);
            if (k < 3) repeat (14) @(negedge clk);
        end
        wait_dv("s2_dv_seen", 1'b0);
        chkw("s2_digest", {256'b0, dg1}, {256'b0, g[RATE-1:0]});
        @(negedge clk);
        chki("s2_nps", nps1 - base, 3);
        chk1("s2_done", done1, 1'b1);
        chk1("s2_ovr", ovr1, 1'b0);

        // 3: OUT_BLOCKS=3 with a stalled consumer
        do_reset();
        digest_ready = 1'b0;
        base = nps3; hbase = nhs3;
        b = {32{8'h5A}};
        send(b, 1'b1);
        g = perm({256'b0, b});
        wait_dv("s3_dv1_seen", 1'b1);
        chkw("s3_digest1", {256'b0, dg3}, {256'b0, g[RATE-1:0]});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("s3_stall_dv", dv3, 1'b1);
            chkw("s3_stall_digest", {256'b0, dg3}, {256'b0, g[RATE-1:0]});
        end
        digest_ready = 1'b1;
        @(negedge clk);
        chk1("s3_dv_drop", dv3, 1'b0);
        g = perm(g);
        wait_dv("s3_dv2_seen", 1'b1);
        chkw("s3_digest2", {256'b0, dg3}, {256'b0, g[RATE-1:0]});
        chk1("s3_not_done2", done3, 1'b0);
        @(negedge clk);
        g = perm(g);
        wait_dv("s3_dv3_seen", 1'b1);
        chkw("s3_digest3", {256'b0, dg3}, {256'b0, g[RATE-1:0]});
        chk1("s3_not_done3", done3, 1'b0);
        @(negedge clk);
        chk1("s3_done", done3, 1'b1);
        chki("s3_nps", nps3 - base, 3);
        chki("s3_nhs", nhs3 - hbase, 3);

        // 4a: one edge during PERM is held and serviced
        do_reset();
        base = nps1;
        a = {32{8'h11}}; b = {32{8'h22}};
        send(a, 1'b0);
        repeat (3) @(negedge clk);
        send(b, 1'b1);
        g = perm({256'b0, a});
        g[RATE-1:0] = g[RATE-1:0] ^ b;
        g = perm(g);
        wait_dv("s4a_dv_seen", 1'b0);
        chkw("s4a_digest", {256'b0, dg1}, {256'b0, g[RATE-1:0]});
        chk1("s4a_ovr", ovr1, 1'b0);
        @(negedge clk);
        chk1("s4a_done", done1, 1'b1);
        chki("s4a_nps", nps1 - base, 2);

        // 4b: two edges during PERM; the second is dropped
        do_reset();
        a = {32{8'h33}}; b = {32{8'h44}}; c = {32{8'h55}};
        send(a, 1'b0);
        repeat (2) @(negedge clk);
        send(b, 1'b1);
        chk1("s4b_ovr_pre", ovr1, 1'b0);
        send(c, 1'b0);
        chk1("s4b_ovr", ovr1, 1'b1);
        g = perm({256'b0, a});
        g[RATE-1:0] = g[RATE-1:0] ^ b;
        g = perm(g);
        wait_dv("s4b_dv_seen", 1'b0);
        chkw("s4b_digest", {256'b0, dg1}, {256'b0, g[RATE-1:0]});

        // 5: asynchronous clear mid-PERM, stale done ignored
        do_reset();
        send({32{8'h66}}, 1'b1);
        repeat (3) @(negedge clk);
        chk1("s5_busy_pre", busy1, 1'b1);
        clear_n = 1'b0;
        #1;
        chk1("s5_busy_clr", busy1, 1'b0);
        chk1("s5_ps_clr", ps1, 1'b0);
        chk1("s5_dv_clr", dv1, 1'b0);
        chkw("s5_psi_clr", psi1, '0);
        @(negedge clk);
        clear_n = 1'b1;
        base = nps1;
        repeat (12) @(negedge clk);
        chk1("s5_stale_busy", busy1, 1'b0);
        chk1("s5_stale_dv", dv1, 1'b0);
        chki("s5_stale_nps", nps1 - base, 0);
        b = {32{8'h77}};
        send(b, 1'b1);
        g = perm({256'b0, b});
        wait_dv("s5_dv_seen", 1'b0);
        chkw("s5_digest", {256'b0, dg1}, {256'b0, g[RATE-1:0]});
        @(negedge clk);
        chk1("s5_done", done1, 1'b1);

`ifdef SPONGE_PERM_TIMEOUT_EN
        // 6: withheld perm_done trips the watchdog at 64 cycles
        hold_done = 1'b1;
        do_reset();
        send({32{8'h99}}, 1'b1);
        chk1("s6_ps", ps1, 1'b1);
        repeat (63) @(negedge clk);
        chk1("s6_tmo_early", tmo1, 1'b0);
        @(negedge clk);
        chk1("s6_tmo", tmo1, 1'b1);
        chk1("s6_done", done1, 1'b0);
        chk1("s6_busy", busy1, 1'b0);
        base = nps1;
        repeat (5) @(negedge clk);
        chki("s6_no_restart", nps1 - base, 0);
        hold_done = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
